// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and size helpers for the MEM stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_to_mask(input mem_size_e size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_to_align(input mem_size_e size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane shift/byte enables and load lane extract/extend
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] i_off,
    input  mem_size_e                   i_size,
    input  logic                        i_unsigned,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [DATA_W-1:0]           i_rdata,
    output logic [DATA_W/8-1:0]         o_be,
    output logic [DATA_W-1:0]           o_wdata,
    output logic [DATA_W-1:0]           o_rdata
);
    localparam int BE_W = DATA_W / 8;

    logic [7:0]                  w_mask8;
    logic [BE_W-1:0]             w_mask;
    logic [$clog2(DATA_W)-1:0]   w_shamt;
    logic [DATA_W-1:0]           w_lane;
    logic                        w_sign;

    assign w_mask8 = size_to_mask(i_size);
    assign w_mask  = w_mask8[BE_W-1:0];
    assign w_shamt = {i_off, 3'b000};
    assign o_be    = w_mask << i_off;
    assign o_wdata = i_wdata << w_shamt;
    assign w_lane  = i_rdata >> w_shamt;

    // Bytes outside the access size are filled with the extension bit.
    always_comb begin
        case (i_size)
            SZ_B:    w_sign = w_lane[7];
            SZ_H:    w_sign = w_lane[15];
            SZ_W:    w_sign = w_lane[31];
            default: w_sign = w_lane[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            o_rdata[i] = w_mask[i/8] ? w_lane[i] : (w_sign & ~i_unsigned);
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: LSU handshake FSM, stall and MEM/WB register
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_m,
    input  logic                mem_read_m,
    input  logic                mem_write_m,
    input  logic [1:0]          mem_size_m,
    input  logic                mem_unsigned_m,
    input  logic                mem_to_reg_m,
    input  logic                reg_write_m,
    input  logic                link_en_m,
    input  logic [DATA_W-1:0]   alu_result_m,
    input  logic [DATA_W-1:0]   write_data_m,
    input  logic [REG_AW-1:0]   dest_reg_m,
    input  logic [DATA_W-1:0]   link_data_m,
    output logic                stall_m,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W/8-1:0] dmem_be,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                valid_w,
    output logic                mem_to_reg_w,
    output logic                reg_write_w,
    output logic                link_en_w,
    output logic                misalign_w,
    output logic [DATA_W-1:0]   mem_data_w,
    output logic [DATA_W-1:0]   alu_result_w,
    output logic [DATA_W-1:0]   link_data_w,
    output logic [REG_AW-1:0]   dest_reg_w
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    mem_size_e          w_size;
    logic               w_access, w_misalign, w_aligned;
    logic [ADDR_W-1:0]  w_addr_aligned;
    logic [BE_W-1:0]    w_be;
    logic [DATA_W-1:0]  w_wdata, w_load_data;
    logic               w_req, w_done, w_store;
    lsu_state_e         w_next;

    lsu_state_e         r_state;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [BE_W-1:0]    r_be;
    logic [DATA_W-1:0]  r_wdata;

    assign w_size     = mem_size_e'(mem_size_m);
    assign w_access   = valid_m & (mem_read_m | mem_write_m);
    assign w_misalign = w_access & ((|(alu_result_m[2:0] & size_to_align(w_size)))
                                    | (w_size == SZ_D && DATA_W == 32));
    assign w_aligned  = w_access & ~w_misalign;
    assign w_addr_aligned = {alu_result_m[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    lsu_align #(.DATA_W(DATA_W)) u_lsu_align (
        .i_off      (alu_result_m[OFF_W-1:0]),
        .i_size     (w_size),
        .i_unsigned (mem_unsigned_m),
        .i_wdata    (write_data_m),
        .i_rdata    (dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_load_data)
    );

    // rvalid only counts once the request has been granted (same cycle or in RSP).
    always_comb begin
        w_req   = 1'b0;
        w_done  = 1'b0;
        w_next  = r_state;
        w_store = (r_state == REQ) ? r_we : mem_write_m;
        case (r_state)
            IDLE, REQ: begin
                w_req = (r_state == REQ) | w_aligned;
                if (w_req) begin
                    if (dmem_gnt) begin
                        w_done = w_store | dmem_rvalid;
                        w_next = w_done ? IDLE : RSP;
                    end else begin
                        w_next = REQ;
                    end
                end
            end
            RSP: begin
                if (dmem_rvalid) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign dmem_req   = rst_n & w_req;
    assign stall_m    = rst_n & w_aligned & ~w_done;
    assign dmem_we    = (r_state == REQ) ? r_we    : mem_write_m;
    assign dmem_addr  = (r_state == REQ) ? r_addr  : w_addr_aligned;
    assign dmem_be    = (r_state == REQ) ? r_be    : w_be;
    assign dmem_wdata = (r_state == REQ) ? r_wdata : w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_we    <= mem_write_m;
                r_addr  <= w_addr_aligned;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || stall_m) begin
            valid_w      <= 1'b0;
            mem_to_reg_w <= 1'b0;
            reg_write_w  <= 1'b0;
            link_en_w    <= 1'b0;
            misalign_w   <= 1'b0;
            mem_data_w   <= '0;
            alu_result_w <= '0;
            link_data_w  <= '0;
            dest_reg_w   <= '0;
        end else begin
            valid_w      <= valid_m;
            mem_to_reg_w <= valid_m & mem_to_reg_m;
            reg_write_w  <= valid_m & reg_write_m & ~w_misalign;
            link_en_w    <= valid_m & link_en_m;
            misalign_w   <= w_misalign;
            mem_data_w   <= (mem_read_m & w_aligned) ? w_load_data : '0;
            alu_result_w <= alu_result_m;
            link_data_w  <= link_data_m;
            dest_reg_w   <= dest_reg_m;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed vector bench for mem_access_stage
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid_m, mem_read_m, mem_write_m, mem_unsigned_m;
    logic        mem_to_reg_m, reg_write_m, link_en_m;
    logic [1:0]  mem_size_m;
    logic [31:0] alu_result_m, write_data_m, link_data_m;
    logic [4:0]  dest_reg_m;
    logic        stall_m, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        valid_w, mem_to_reg_w, reg_write_w, link_en_w, misalign_w;
    logic [31:0] mem_data_w, alu_result_w, link_data_w;
    logic [4:0]  dest_reg_w;

    logic        q_valid_m, q_mem_read_m, q_mem_write_m, q_mem_unsigned_m;
    logic [1:0]  q_mem_size_m;
    logic [63:0] q_alu_result_m, q_write_data_m, q_dmem_rdata;
    logic        q_stall_m, q_dmem_req, q_dmem_we, q_dmem_gnt, q_dmem_rvalid;
    logic [31:0] q_dmem_addr;
    logic [7:0]  q_dmem_be;
    logic [63:0] q_dmem_wdata, q_mem_data_w, q_alu_result_w, q_link_data_w;
    logic        q_valid_w, q_mem_to_reg_w, q_reg_write_w, q_link_en_w, q_misalign_w;
    logic [4:0]  q_dest_reg_w;

    mem_access_stage #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .mem_read_m(mem_read_m),
        .mem_write_m(mem_write_m), .mem_size_m(mem_size_m), .mem_unsigned_m(mem_unsigned_m),
        .mem_to_reg_m(mem_to_reg_m), .reg_write_m(reg_write_m), .link_en_m(link_en_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .dest_reg_m(dest_reg_m),
        .link_data_m(link_data_m), .stall_m(stall_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .valid_w(valid_w), .mem_to_reg_w(mem_to_reg_w), .reg_write_w(reg_write_w),
        .link_en_w(link_en_w), .misalign_w(misalign_w), .mem_data_w(mem_data_w),
        .alu_result_w(alu_result_w), .link_data_w(link_data_w), .dest_reg_w(dest_reg_w)
    );

    mem_access_stage #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .valid_m(q_valid_m), .mem_read_m(q_mem_read_m),
        .mem_write_m(q_mem_write_m), .mem_size_m(q_mem_size_m), .mem_unsigned_m(q_mem_unsigned_m),
        .mem_to_reg_m(q_mem_read_m), .reg_write_m(q_mem_read_m), .link_en_m(1'b0),
        .alu_result_m(q_alu_result_m), .write_data_m(q_write_data_m), .dest_reg_m(5'd9),
        .link_data_m(64'd0), .stall_m(q_stall_m), .dmem_req(q_dmem_req), .dmem_we(q_dmem_we),
        .dmem_addr(q_dmem_addr), .dmem_be(q_dmem_be), .dmem_wdata(q_dmem_wdata),
        .dmem_gnt(q_dmem_gnt), .dmem_rvalid(q_dmem_rvalid), .dmem_rdata(q_dmem_rdata),
        .valid_w(q_valid_w), .mem_to_reg_w(q_mem_to_reg_w), .reg_write_w(q_reg_write_w),
        .link_en_w(q_link_en_w), .misalign_w(q_misalign_w), .mem_data_w(q_mem_data_w),
        .alu_result_w(q_alu_result_w), .link_data_w(q_link_data_w), .dest_reg_w(q_dest_reg_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_addr;
        logic        exp_mis;
        logic        exp_rw;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] dest);
        valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; mem_size_m = size;
        mem_unsigned_m = uns; mem_to_reg_m = rd; reg_write_m = ~wr; link_en_m = 1'b0;
        alu_result_m = addr; write_data_m = wd; dest_reg_m = dest;
        link_data_m = 32'h0000_0400;
    endtask

    task automatic drive_idle();
        valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; mem_size_m = 2'b00;
        mem_unsigned_m = 1'b0; mem_to_reg_m = 1'b0; reg_write_m = 1'b0; link_en_m = 1'b0;
        alu_result_m = '0; write_data_m = '0; dest_reg_m = '0; link_data_m = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    int bubbles;

    initial begin
        drive_idle();
        q_valid_m = 1'b0; q_mem_read_m = 1'b0; q_mem_write_m = 1'b0; q_mem_size_m = 2'b00;
        q_mem_unsigned_m = 1'b0; q_alu_result_m = '0; q_write_data_m = '0;
        q_dmem_gnt = 1'b0; q_dmem_rvalid = 1'b0; q_dmem_rdata = '0;

        //           rd    wr    sz     uns   addr          wdata         rdata         req   be       wdata         addr          mis   rw    data
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h8000_0000, 1'b1, 4'b1000, 32'h0,        32'h0000_1000, 1'b0, 1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h8000_0000, 1'b1, 4'b1000, 32'h0,        32'h0000_1000, 1'b0, 1'b1, 32'h0000_0080};
        vecs[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        1'b1, 4'b1100, 32'hBEEF_0000, 32'h0000_2000, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0,        32'h8001_1234, 1'b1, 4'b1100, 32'h0,        32'h0000_1000, 1'b0, 1'b1, 32'hFFFF_8001};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0,        32'h8001_1234, 1'b1, 4'b1100, 32'h0,        32'h0000_1000, 1'b0, 1'b1, 32'h0000_8001};
        vecs[5]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0,        32'h0000_1004, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00A5, 32'h0,        1'b1, 4'b0010, 32'h0000_A500, 32'h0000_3000, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0,        32'h1111_1111, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0,        32'h1111_1111, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1001, 32'h0,        32'h1111_1111, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,         1'b0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0,        32'h0000_7F00, 1'b1, 4'b0010, 32'h0,        32'h0000_1000, 1'b0, 1'b1, 32'h0000_007F};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_w", valid_w, 0);
        chk("rst_stall", stall_m, 0);
        chk("rst_req", dmem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait table vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_op(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr,
                     vecs[i].wdata, 5'(i + 1));
            dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_stall", i), stall_m, 0);
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d_be", i), dmem_be, vecs[i].exp_be);
                chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_we", i), dmem_we, vecs[i].wr);
                if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_w", i), valid_w, 1);
            chk($sformatf("v%0d_misalign_w", i), misalign_w, vecs[i].exp_mis);
            chk($sformatf("v%0d_reg_write_w", i), reg_write_w, vecs[i].exp_rw);
            chk($sformatf("v%0d_mem_data_w", i), mem_data_w, vecs[i].exp_data);
            chk($sformatf("v%0d_alu_result_w", i), alu_result_w, vecs[i].addr);
            chk($sformatf("v%0d_dest_reg_w", i), dest_reg_w, 5'(i + 1));
        end
        @(negedge clk);
        drive_idle();

        // LW: gnt on the third cycle, rvalid three cycles after gnt
        bubbles = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd7);
            dmem_gnt = (i == 2);
            dmem_rvalid = (i == 1) || (i == 5);
            dmem_rdata = (i == 5) ? 32'hCAFE_F00D : 32'h5555_5555;
            #1;
            chk($sformatf("lat%0d_stall", i), stall_m, (i < 5));
            chk($sformatf("lat%0d_req", i), dmem_req, (i <= 2));
            if (i <= 2) chk($sformatf("lat%0d_addr", i), dmem_addr, 32'h0000_4000);
            @(posedge clk);
            #1;
            if (valid_w == 1'b0 && reg_write_w == 1'b0) bubbles++;
            if (i == 5) begin
                chk("lat_valid_w", valid_w, 1);
                chk("lat_mem_data_w", mem_data_w, 32'hCAFE_F00D);
                chk("lat_dest_reg_w", dest_reg_w, 5'd7);
            end
        end
        chk("lat_bubbles", bubbles, 5);
        @(negedge clk);
        drive_idle();

        // Reset while waiting for rvalid
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 5'd3);
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        chk("rsp_stall", stall_m, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstrsp_stall", stall_m, 0);
        chk("rstrsp_req", dmem_req, 0);
        chk("rstrsp_valid_w", valid_w, 0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("stray_req", dmem_req, 0);
        @(posedge clk);
        #1;
        chk("stray_valid_w", valid_w, 0);
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6008, 32'h0, 5'd4);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        #1;
        chk("post_stall", stall_m, 0);
        chk("post_addr", dmem_addr, 32'h0000_6008);
        @(posedge clk);
        #1;
        chk("post_valid_w", valid_w, 1);
        chk("post_mem_data_w", mem_data_w, 32'h1234_5678);
        @(negedge clk);
        drive_idle();

        // 64-bit datapath: LD and an upper-lane signed LW
        @(negedge clk);
        q_valid_m = 1'b1; q_mem_read_m = 1'b1; q_mem_size_m = 2'b11; q_alu_result_m = 64'h8;
        q_dmem_gnt = 1'b1; q_dmem_rvalid = 1'b1; q_dmem_rdata = 64'h8877_6655_4433_2211;
        #1;
        chk("d64_ld_be", q_dmem_be, 8'hFF);
        chk("d64_ld_addr", q_dmem_addr, 32'h8);
        chk("d64_ld_stall", q_stall_m, 0);
        @(posedge clk);
        #1;
        chk("d64_ld_data", q_mem_data_w, 64'h8877_6655_4433_2211);
        chk("d64_ld_misalign", q_misalign_w, 0);
        @(negedge clk);
        q_mem_size_m = 2'b10; q_alu_result_m = 64'hC; q_dmem_rdata = 64'h8000_0000_0000_0000;
        #1;
        chk("d64_lw_be", q_dmem_be, 8'hF0);
        @(posedge clk);
        #1;
        chk("d64_lw_data", q_mem_data_w, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        q_valid_m = 1'b0; q_mem_read_m = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
